// File: rtl/sync_fifo_pkg.sv
// Shared constants and elaboration helpers for the parametrised single-clock FIFO.
// The pointer width includes one wrap bit above the memory address.
package sync_fifo_pkg;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_DEPTH     = 16;
    localparam int DEF_AFULL_TH  = 12;
    localparam int DEF_AEMPTY_TH = 4;
    localparam int DEF_FWFT      = 0;

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Depth must be a power of two so the wrap bit alone distinguishes full from empty.
    function automatic bit params_ok(input int width, input int depth, input int afull_th,
                                     input int aempty_th, input int fwft);
        bit ok;
        ok = 1'b1;
        if (width < 1)                       ok = 1'b0;
        if (depth < 2)                       ok = 1'b0;
        if ((depth & (depth - 1)) != 0)      ok = 1'b0;
        if (afull_th < 1 || afull_th > depth) ok = 1'b0;
        if (aempty_th < 0)                   ok = 1'b0;
        if (aempty_th >= afull_th)           ok = 1'b0;
        if (fwft != 0 && fwft != 1)          ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Binary FIFO pointer with a wrap bit; the low AW bits address the memory.
// Used once for the write side and once for the read side.
module fifo_ptr #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          resetb,
    input  logic          inc,
    output logic [AW:0]   ptr,
    output logic [AW-1:0] addr
);

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + (AW + 1)'(1);
        end
    end

    assign addr = ptr[AW-1:0];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/almost-empty
// thresholds, optional first-word-fall-through output and sticky error flags.
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AFULL_TH  = DEF_AFULL_TH,
    parameter int AEMPTY_TH = DEF_AEMPTY_TH,
    parameter int FWFT      = DEF_FWFT
) (
    input  logic                     clk,
    input  logic                     resetb,
    input  logic                     wr,
    input  logic [WIDTH-1:0]         din,
    input  logic                     rd,
    input  logic                     clr_err,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic                     afull,
    output logic                     aempty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf,
    output logic                     udf
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = ptr_w(DEPTH);

    if (!params_ok(WIDTH, DEPTH, AFULL_TH, AEMPTY_TH, FWFT)) begin : g_param_err
        $error("sync_fifo_param: illegal parameters WIDTH=%0d DEPTH=%0d AFULL_TH=%0d AEMPTY_TH=%0d FWFT=%0d",
               WIDTH, DEPTH, AFULL_TH, AEMPTY_TH, FWFT);
    end

    localparam logic [PW-1:0] DEPTH_C  = PW'(DEPTH);
    localparam logic [PW-1:0] AFULL_C  = PW'(AFULL_TH);
    localparam logic [PW-1:0] AEMPTY_C = PW'(AEMPTY_TH);

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_addr;
    logic [AW-1:0]    rd_addr;
    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] mem [DEPTH];

    // wr/rd are requests, not handshakes: a request is taken on the rising edge
    // only if full (for wr) or empty (for rd) was low before that edge; a refused
    // request is dropped and recorded in ovf/udf. full/empty are the only ready
    // indications and never depend combinationally on wr or rd.
    assign wr_en = wr & ~full;
    assign rd_en = rd & ~empty;

    fifo_ptr #(.AW(AW)) u_wr_ptr (
        .clk    (clk),
        .resetb (resetb),
        .inc    (wr_en),
        .ptr    (wr_ptr),
        .addr   (wr_addr)
    );

    fifo_ptr #(.AW(AW)) u_rd_ptr (
        .clk    (clk),
        .resetb (resetb),
        .inc    (rd_en),
        .ptr    (rd_ptr),
        .addr   (rd_addr)
    );

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= din;
        end
    end

    // Modular subtraction over the wrap bit yields 0..DEPTH directly.
    assign count  = wr_ptr - rd_ptr;
    assign full   = (count == DEPTH_C);
    assign empty  = (count == '0);
    assign afull  = (count >= AFULL_C);
    assign aempty = (count <= AEMPTY_C);

    if (FWFT != 0) begin : g_fwft
        // Head word is shown as soon as it is stored; rd acknowledges it.
        assign dout = mem[rd_addr];
    end else begin : g_reg_read
        always_ff @(posedge clk or negedge resetb) begin
            if (!resetb) begin
                dout <= '0;
            end else if (rd_en) begin
                dout <= mem[rd_addr];
            end
        end
    end

    // A new error in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            if (wr && full) begin
                ovf <= 1'b1;
            end else if (clr_err) begin
                ovf <= 1'b0;
            end
            if (rd && empty) begin
                udf <= 1'b1;
            end else if (clr_err) begin
                udf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: a registered-read instance checked against a queue
// model, plus a first-word-fall-through instance for the FWFT behaviour.
module tb_sync_fifo_param;

    logic       clk;
    logic       resetb;
    logic       wr, rd, clr_err;
    logic [7:0] din, dout;
    logic       full, empty, afull, aempty, ovf, udf;
    logic [4:0] count;

    logic       wr_f, rd_f, clr_err_f;
    logic [7:0] din_f, dout_f;
    logic       full_f, empty_f, afull_f, aempty_f, ovf_f, udf_f;
    logic [4:0] count_f;

    int n_cmp;
    int n_err;

    logic [7:0] exp_q[$];
    int         m_count;
    logic       m_ovf, m_udf;
    logic [7:0] m_dout;

    sync_fifo_param #(.WIDTH(8), .DEPTH(16), .AFULL_TH(12), .AEMPTY_TH(4), .FWFT(0)) u_dut (
        .clk(clk), .resetb(resetb), .wr(wr), .din(din), .rd(rd), .clr_err(clr_err),
        .dout(dout), .full(full), .empty(empty), .afull(afull), .aempty(aempty),
        .count(count), .ovf(ovf), .udf(udf)
    );

    sync_fifo_param #(.WIDTH(8), .DEPTH(16), .AFULL_TH(12), .AEMPTY_TH(4), .FWFT(1)) u_dut_fwft (
        .clk(clk), .resetb(resetb), .wr(wr_f), .din(din_f), .rd(rd_f), .clr_err(clr_err_f),
        .dout(dout_f), .full(full_f), .empty(empty_f), .afull(afull_f), .aempty(aempty_f),
        .count(count_f), .ovf(ovf_f), .udf(udf_f)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Driver for the registered-read instance; the model decides acceptance from
    // the pre-edge occupancy, pushes accepted writes and pops accepted reads.
    task automatic cycle(input logic w, input logic [7:0] d, input logic r, input logic c,
                         output logic popped, output logic [7:0] exp_w);
        bit acc_w, acc_r;
        wr = w; din = d; rd = r; clr_err = c;
        acc_w = w && (m_count < 16);
        acc_r = r && (m_count > 0);
        popped = 1'b0;
        exp_w  = m_dout;
        if (acc_r) begin
            exp_w  = exp_q.pop_front();
            popped = 1'b1;
            m_dout = exp_w;
        end
        if (acc_w) exp_q.push_back(d);
        if (w && m_count == 16) m_ovf = 1'b1; else if (c) m_ovf = 1'b0;
        if (r && m_count == 0)  m_udf = 1'b1; else if (c) m_udf = 1'b0;
        m_count = m_count + int'(acc_w) - int'(acc_r);
        tick();
        wr = 1'b0; rd = 1'b0; clr_err = 1'b0;
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_count = 0; m_ovf = 1'b0; m_udf = 1'b0; m_dout = 8'h00;
    endtask

    task automatic test_reset();
        resetb = 1'b0;
        wr = 0; rd = 0; clr_err = 0; din = 0;
        wr_f = 0; rd_f = 0; clr_err_f = 0; din_f = 0;
        model_reset();
        tick(); tick();
        n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
        n_cmp++; if ({empty, aempty, full, afull} !== 4'b1100) begin n_err++; $display("FAIL reset_flags: got %b want 1100", {empty, aempty, full, afull}); end
        n_cmp++; if ({ovf, udf} !== 2'b00) begin n_err++; $display("FAIL reset_err: got %b want 00", {ovf, udf}); end
        n_cmp++; if (dout !== 8'h00) begin n_err++; $display("FAIL reset_dout: got %h want 00", dout); end
        n_cmp++; if ({empty_f, count_f} !== {1'b1, 5'd0}) begin n_err++; $display("FAIL reset_fwft: got %b/%0d want 1/0", empty_f, count_f); end
        resetb = 1'b1;
        tick();
    endtask

    task automatic test_fill();
        logic p; logic [7:0] e;
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 8'(i), 1'b0, 1'b0, p, e);
            n_cmp++; if (count !== 5'(m_count)) begin n_err++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, m_count); end
            n_cmp++; if (afull !== (m_count >= 12)) begin n_err++; $display("FAIL fill_afull[%0d]: got %b want %b", i, afull, m_count >= 12); end
            n_cmp++; if (full !== (m_count == 16)) begin n_err++; $display("FAIL fill_full[%0d]: got %b want %b", i, full, m_count == 16); end
        end
        cycle(1'b1, 8'hEE, 1'b0, 1'b0, p, e);
        n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL fill_ovf: got %b want 1", ovf); end
        n_cmp++; if (count !== 5'd16) begin n_err++; $display("FAIL fill_ovf_count: got %0d want 16", count); end
    endtask

    task automatic test_drain();
        logic p; logic [7:0] e;
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0, p, e);
            n_cmp++; if (!p || dout !== e) begin n_err++; $display("FAIL drain_dout[%0d]: got %h want %h popped=%b", i, dout, e, p); end
            n_cmp++; if (aempty !== (m_count <= 4)) begin n_err++; $display("FAIL drain_aempty[%0d]: got %b want %b", i, aempty, m_count <= 4); end
            n_cmp++; if (empty !== (m_count == 0)) begin n_err++; $display("FAIL drain_empty[%0d]: got %b want %b", i, empty, m_count == 0); end
        end
        cycle(1'b0, 8'h00, 1'b1, 1'b0, p, e);
        n_cmp++; if (udf !== 1'b1) begin n_err++; $display("FAIL drain_udf: got %b want 1", udf); end
        n_cmp++; if (dout !== 8'h0F) begin n_err++; $display("FAIL drain_hold: got %h want 0f", dout); end
        cycle(1'b0, 8'h00, 1'b0, 1'b1, p, e);
        n_cmp++; if ({ovf, udf} !== {m_ovf, m_udf}) begin n_err++; $display("FAIL drain_clr: got %b want %b", {ovf, udf}, {m_ovf, m_udf}); end
    endtask

    task automatic test_back_to_back();
        logic p; logic [7:0] e;
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, p, e);
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0, p, e);
            n_cmp++; if (count !== 5'd5) begin n_err++; $display("FAIL b2b_count[%0d]: got %0d want 5", i, count); end
            n_cmp++; if (!p || dout !== e) begin n_err++; $display("FAIL b2b_dout[%0d]: got %h want %h", i, dout, e); end
        end
        for (int i = 0; i < 11; i++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, p, e);
        n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL b2b_full: got %b want 1", full); end
        // At full the read goes through and the write is refused.
        cycle(1'b1, 8'h77, 1'b1, 1'b0, p, e);
        n_cmp++; if (count !== 5'd15) begin n_err++; $display("FAIL full_rw_count: got %0d want 15", count); end
        n_cmp++; if (dout !== e) begin n_err++; $display("FAIL full_rw_dout: got %h want %h", dout, e); end
        n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL full_rw_ovf: got %b want 1", ovf); end
        for (int i = 0; i < 15; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0, p, e);
            n_cmp++; if (dout !== e) begin n_err++; $display("FAIL b2b_drain[%0d]: got %h want %h", i, dout, e); end
        end
        // At empty the write goes through and the read is refused.
        cycle(1'b1, 8'h5A, 1'b1, 1'b0, p, e);
        n_cmp++; if (count !== 5'd1) begin n_err++; $display("FAIL empty_rw_count: got %0d want 1", count); end
        n_cmp++; if (udf !== 1'b1) begin n_err++; $display("FAIL empty_rw_udf: got %b want 1", udf); end
        n_cmp++; if (dout !== e) begin n_err++; $display("FAIL empty_rw_hold: got %h want %h", dout, e); end
        cycle(1'b0, 8'h00, 1'b1, 1'b1, p, e);
        n_cmp++; if (dout !== 8'h5A || !p) begin n_err++; $display("FAIL empty_rw_data: got %h want 5a", dout); end
        n_cmp++; if ({ovf, udf, empty} !== 3'b001) begin n_err++; $display("FAIL b2b_end: got %b want 001", {ovf, udf, empty}); end
    endtask

    task automatic test_fwft();
        logic [7:0] fq[$];
        logic [7:0] w;
        wr_f = 1'b1; din_f = 8'hA5;
        tick();
        wr_f = 1'b0;
        n_cmp++; if (empty_f !== 1'b0) begin n_err++; $display("FAIL fwft_empty: got %b want 0", empty_f); end
        n_cmp++; if (dout_f !== 8'hA5) begin n_err++; $display("FAIL fwft_dout: got %h want a5", dout_f); end
        tick();
        n_cmp++; if (dout_f !== 8'hA5 || count_f !== 5'd1) begin n_err++; $display("FAIL fwft_hold: got %h/%0d want a5/1", dout_f, count_f); end
        rd_f = 1'b1;
        tick();
        rd_f = 1'b0;
        n_cmp++; if (empty_f !== 1'b1) begin n_err++; $display("FAIL fwft_pop: got %b want 1", empty_f); end
        for (int i = 0; i < 4; i++) begin
            w = 8'($urandom_range(0, 255));
            fq.push_back(w);
            wr_f = 1'b1; din_f = w;
            tick();
        end
        wr_f = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w = fq.pop_front();
            n_cmp++; if (empty_f !== 1'b0 || dout_f !== w) begin n_err++; $display("FAIL fwft_seq[%0d]: got %h want %h", i, dout_f, w); end
            rd_f = 1'b1;
            tick();
            rd_f = 1'b0;
        end
        n_cmp++; if (empty_f !== 1'b1 || udf_f !== 1'b0) begin n_err++; $display("FAIL fwft_end: got %b%b want 10", empty_f, udf_f); end
    endtask

    task automatic test_reset_mid();
        logic p; logic [7:0] e;
        for (int i = 0; i < 9; i++) cycle(1'b1, 8'(8'h90 + i), 1'b0, 1'b0, p, e);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, p, e);
        n_cmp++; if (count !== 5'd8 || dout !== 8'h90) begin n_err++; $display("FAIL mid_pre: got %0d/%h want 8/90", count, dout); end
        wr = 1'b1; din = 8'hBB;
        #2 resetb = 1'b0;
        #1;
        model_reset();
        n_cmp++; if (count !== 5'd0 || {empty, aempty, full, afull} !== 4'b1100) begin n_err++; $display("FAIL mid_reset_flags: got %0d/%b want 0/1100", count, {empty, aempty, full, afull}); end
        n_cmp++; if (dout !== 8'h00 || {ovf, udf} !== 2'b00) begin n_err++; $display("FAIL mid_reset_dout: got %h/%b want 00/00", dout, {ovf, udf}); end
        wr = 1'b0;
        tick();
        #2 resetb = 1'b1;
        tick();
        cycle(1'b1, 8'h3C, 1'b0, 1'b0, p, e);
        n_cmp++; if (count !== 5'd1) begin n_err++; $display("FAIL mid_after_count: got %0d want 1", count); end
        cycle(1'b0, 8'h00, 1'b1, 1'b0, p, e);
        n_cmp++; if (dout !== 8'h3C || !p || e !== 8'h3C) begin n_err++; $display("FAIL mid_after_dout: got %h want 3c", dout); end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL mid_after_empty: got %b want 1", empty); end
    endtask

    task automatic test_err_clear();
        logic p; logic [7:0] e;
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, p, e);
        cycle(1'b1, 8'h11, 1'b0, 1'b0, p, e);
        n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL err_ovf_set: got %b want 1", ovf); end
        cycle(1'b1, 8'h22, 1'b0, 1'b1, p, e);
        n_cmp++; if (ovf !== m_ovf || ovf !== 1'b1) begin n_err++; $display("FAIL err_set_wins: got %b want 1", ovf); end
        cycle(1'b0, 8'h00, 1'b0, 1'b1, p, e);
        n_cmp++; if ({ovf, udf} !== 2'b00) begin n_err++; $display("FAIL err_clear: got %b want 00", {ovf, udf}); end
        n_cmp++; if (count !== 5'(m_count)) begin n_err++; $display("FAIL err_count: got %0d want %0d", count, m_count); end
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0, p, e);
            n_cmp++; if (dout !== e) begin n_err++; $display("FAIL err_drain[%0d]: got %h want %h", i, dout, e); end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_fwft();
        test_reset_mid();
        test_err_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
